masked_half_sequencer: RTL and testbench

//  Shares one HALF_WIDTH-wide masked unit between the two halves of a 2*HALF_WIDTH shared word.
//  - Accepts a shared word and splits it per share into low/high halves.
//  - Issues low then high half to the unit on consecutive cycles, captures both results
//    (fixed unit latency), then joins them per share: {hi, lo}.
//  - Sits between the wide pipeline and any half-width masked stage; no unmasking ever occurs.

---
 rtl/masked_half_sequencer.sv | 104 ++++++++++
 tb/tb_masked_half_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_half_sequencer.sv
// Time-shares one half-width masked unit across both halves of a wide shared word.
// Low half issues first, then high half; results are rejoined per share as {hi, lo}.
module masked_half_sequencer #(
  parameter int NUM_SHARES = 2,
  parameter int HALF_WIDTH = 15,
  parameter int LATENCY    = 3
) (
  input  logic                                       in_clock,
  input  logic                                       in_reset_n,
  input  logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0]    in_a,
  input  logic                                       in_a_valid,
  output logic                                       out_a_ready,
  output logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]      out_unit_a,
  output logic                                       out_unit_valid,
  input  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]      in_unit_b,
  output logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0]    out_b,
  output logic                                       out_b_valid,
  input  logic                                       in_b_ready
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_LO, S_ISSUE_HI, S_WAIT, S_DONE
  } state_e;

  state_e                                  state_q, state_d;
  logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0] op_q, op_d;
  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]   lo_q, lo_d;
  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]   hi_q, hi_d;
  logic [CW-1:0]                           cnt_q, cnt_d;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts down over WAIT; the low result lands one cycle before the high one,
  // which for LATENCY==1 falls into ISSUE_HI itself.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_a_valid) begin
          op_d    = in_a;
          state_d = S_ISSUE_LO;
        end
      end
      S_ISSUE_LO: state_d = S_ISSUE_HI;
      S_ISSUE_HI: begin
        op_d    = '0;
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
        if (LATENCY == 1) lo_d = in_unit_b;
      end
      S_WAIT: begin
        if (LATENCY > 1 && cnt_q == CW'(1)) lo_d = in_unit_b;
        if (cnt_q == '0) begin
          hi_d    = in_unit_b;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (in_b_ready) begin
          lo_d    = '0;
          hi_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by reset so ready stays low while reset is held.
  assign out_a_ready    = in_reset_n & (state_q == S_IDLE);
  assign out_unit_valid = (state_q == S_ISSUE_LO) || (state_q == S_ISSUE_HI);
  assign out_b_valid    = (state_q == S_DONE);

  for (genvar g = 0; g < NUM_SHARES; g++) begin : g_share
    assign out_unit_a[g] = (state_q == S_ISSUE_LO) ? op_q[g][HALF_WIDTH-1:0] :
                           (state_q == S_ISSUE_HI) ? op_q[g][2*HALF_WIDTH-1:HALF_WIDTH] :
                                                     '0;
    assign out_b[g]      = (state_q == S_DONE) ? {hi_q[g], lo_q[g]} : '0;
  end

endmodule

// File: tb/tb_masked_half_sequencer.sv
// Bench for masked_half_sequencer: XOR-15'h1234 unit model with 3-cycle latency,
// scoreboard of expected joined results checked at every output handshake.
module tb_masked_half_sequencer;
  localparam int NS = 2;
  localparam int HW = 15;
  localparam logic [HW-1:0] K = 15'h1234;

  typedef logic [NS-1:0][2*HW-1:0] word_t;
  typedef logic [NS-1:0][HW-1:0]   half_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  word_t in_a = '0;
  logic  in_a_valid = 1'b0;
  logic  out_a_ready;
  half_t out_unit_a;
  logic  out_unit_valid;
  half_t in_unit_b;
  word_t out_b;
  logic  out_b_valid;
  logic  in_b_ready = 1'b0;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  word_t sb[$];
  half_t p0 = '0, p1 = '0, p2 = '0;

  masked_half_sequencer #(.NUM_SHARES(NS), .HALF_WIDTH(HW), .LATENCY(3)) dut (
    .in_clock(clk), .in_reset_n(rst_n),
    .in_a(in_a), .in_a_valid(in_a_valid), .out_a_ready(out_a_ready),
    .out_unit_a(out_unit_a), .out_unit_valid(out_unit_valid), .in_unit_b(in_unit_b),
    .out_b(out_b), .out_b_valid(out_b_valid), .in_b_ready(in_b_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic half_t unit_f(half_t a);
    half_t r;
    for (int s = 0; s < NS; s++) r[s] = a[s] ^ K;
    return r;
  endfunction

  function automatic word_t exp_of(word_t a);
    word_t r;
    for (int s = 0; s < NS; s++) r[s] = {a[s][2*HW-1:HW] ^ K, a[s][HW-1:0] ^ K};
    return r;
  endfunction

  function automatic word_t rnd_word();
    word_t r;
    for (int s = 0; s < NS; s++) r[s] = 30'($urandom);
    return r;
  endfunction

  // Unit model: issue at t is visible on in_unit_b during t+3.
  always @(posedge clk) begin
    p0 <= out_unit_valid ? unit_f(out_unit_a) : '0;
    p1 <= p0;
    p2 <= p1;
  end
  assign in_unit_b = p2;

  task automatic monitor();
    word_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!out_unit_valid) begin
          vec++;
          if (out_unit_a !== '0) begin err++; $display("FAIL idle_unit_a: got %h want 0", out_unit_a); end
        end
        if (!out_b_valid) begin
          vec++;
          if (out_b !== '0) begin err++; $display("FAIL idle_out_b: got %h want 0", out_b); end
        end
        if (out_b_valid && in_b_ready) begin
          vec++;
          if (sb.size() == 0) begin
            err++; $display("FAIL unexpected_result: got %h want no result", out_b);
          end else begin
            e = sb.pop_front();
            if (out_b !== e) begin err++; $display("FAIL scoreboard: got %h want %h", out_b, e); end
          end
        end
      end
    end
  endtask

  // Drives one accept cycle (cycle 0); returns just after the accepting edge.
  task automatic issue(input word_t w, input bit push);
    @(posedge clk); #1;
    in_a = w; in_a_valid = 1'b1;
    if (push) sb.push_back(exp_of(w));
    @(posedge clk); #1;
    in_a_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_b_ready = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({out_a_ready, out_unit_valid, out_b_valid} !== 3'b000 || out_unit_a !== '0 || out_b !== '0) begin
      err++; $display("FAIL reset_outputs: got rdy=%b uv=%b bv=%b ua=%h b=%h want all 0",
                      out_a_ready, out_unit_valid, out_b_valid, out_unit_a, out_b);
    end
    rst_n = 1'b1; #1;
    vec++;
    if (out_a_ready !== 1'b1) begin err++; $display("FAIL reset_release_ready: got %b want 1", out_a_ready); end
    in_b_ready = 1'b1;
  endtask

  task automatic test_basic();
    word_t w;
    half_t lo, hi;
    w = {30'h2AAA_5555, 30'h1555_0F0F};
    for (int s = 0; s < NS; s++) begin lo[s] = w[s][HW-1:0]; hi[s] = w[s][2*HW-1:HW]; end
    @(posedge clk); #1;
    in_a = w; in_a_valid = 1'b1;
    sb.push_back(exp_of(w));
    @(negedge clk);
    vec++;
    if (out_a_ready !== 1'b1) begin err++; $display("FAIL basic_ready_c0: got %b want 1", out_a_ready); end
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_a_valid = 1'b0;
      @(negedge clk);
      vec++;
      if (out_unit_valid !== (c == 1 || c == 2)) begin
        err++; $display("FAIL basic_unit_valid c%0d: got %b want %b", c, out_unit_valid, (c == 1 || c == 2));
      end
      if (c == 1) begin
        vec++;
        if (out_unit_a !== lo) begin err++; $display("FAIL basic_lo_issue: got %h want %h", out_unit_a, lo); end
      end
      if (c == 2) begin
        vec++;
        if (out_unit_a !== hi) begin err++; $display("FAIL basic_hi_issue: got %h want %h", out_unit_a, hi); end
      end
      vec++;
      if (out_b_valid !== (c == 6)) begin
        err++; $display("FAIL basic_b_valid c%0d: got %b want %b", c, out_b_valid, (c == 6));
      end
      if (c == 6) begin
        vec++;
        if (out_b !== exp_of(w)) begin err++; $display("FAIL basic_out_b: got %h want %h", out_b, exp_of(w)); end
      end
      vec++;
      if (out_a_ready !== (c == 7)) begin
        err++; $display("FAIL basic_ready c%0d: got %b want %b", c, out_a_ready, (c == 7));
      end
    end
  endtask

  task automatic test_stall();
    word_t w;
    int n;
    w = rnd_word();
    in_b_ready = 1'b0;
    issue(w, 1'b1);
    n = 1;
    @(negedge clk);
    while (!out_b_valid && n < 20) begin
      @(posedge clk); #1; n++;
      @(negedge clk);
    end
    vec++;
    if (!(out_b_valid === 1'b1 && n == 6)) begin
      err++; $display("FAIL stall_done_cycle: got valid=%b at cycle %0d want valid=1 at cycle 6", out_b_valid, n);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; @(negedge clk); end
      vec++;
      if (out_b_valid !== 1'b1 || out_b !== exp_of(w) || out_a_ready !== 1'b0) begin
        err++; $display("FAIL stall_hold k%0d: got bv=%b b=%h rdy=%b want bv=1 b=%h rdy=0",
                        k, out_b_valid, out_b, out_a_ready, exp_of(w));
      end
    end
    @(posedge clk); #1; in_b_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (out_b_valid !== 1'b1 || out_a_ready !== 1'b0) begin
      err++; $display("FAIL stall_handshake: got bv=%b rdy=%b want bv=1 rdy=0", out_b_valid, out_a_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if (out_a_ready !== 1'b1 || out_b_valid !== 1'b0) begin
      err++; $display("FAIL stall_after: got rdy=%b bv=%b want rdy=1 bv=0", out_a_ready, out_b_valid);
    end
  endtask

  task automatic test_back_to_back();
    word_t words[3];
    int acc[3];
    int k;
    for (int i = 0; i < 3; i++) words[i] = rnd_word();
    k = 0;
    in_b_ready = 1'b1;
    for (int t = 0; t < 60 && (k < 3 || sb.size() > 0); t++) begin
      @(posedge clk); #1;
      if (k < 3) begin in_a = words[k]; in_a_valid = 1'b1; end
      else in_a_valid = 1'b0;
      @(negedge clk);
      if (out_a_ready && in_a_valid && k < 3) begin
        acc[k] = cyc;
        sb.push_back(exp_of(words[k]));
        k++;
      end
    end
    in_a_valid = 1'b0;
    vec++;
    if (k != 3 || sb.size() != 0) begin
      err++; $display("FAIL b2b_complete: got accepts=%0d pending=%0d want accepts=3 pending=0", k, sb.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vec++;
        if (acc[i] - acc[i-1] != 7) begin
          err++; $display("FAIL b2b_spacing %0d: got %0d want 7", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_ignore();
    word_t a, b;
    a = rnd_word();
    b = ~a;
    in_b_ready = 1'b1;
    issue(a, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      in_a = b;
      in_a_valid = (c == 1 || c == 3 || c == 6);
      @(negedge clk);
      if (c <= 6) begin
        vec++;
        if (out_a_ready !== 1'b0) begin err++; $display("FAIL ignore_ready c%0d: got %b want 0", c, out_a_ready); end
      end
      if (c == 6) begin
        vec++;
        if (out_b_valid !== 1'b1 || out_b !== exp_of(a)) begin
          err++; $display("FAIL ignore_result: got bv=%b b=%h want bv=1 b=%h", out_b_valid, out_b, exp_of(a));
        end
      end
      if (c == 8) begin
        vec++;
        if (out_unit_valid !== 1'b0) begin err++; $display("FAIL ignore_no_queue: got uv=%b want 0", out_unit_valid); end
      end
    end
    in_a_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    word_t a, c;
    bit seen;
    int n;
    a = rnd_word();
    c = rnd_word();
    in_b_ready = 1'b1;
    issue(a, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({out_a_ready, out_unit_valid, out_b_valid} !== 3'b000 || out_unit_a !== '0 || out_b !== '0) begin
      err++; $display("FAIL abort_outputs: got rdy=%b uv=%b bv=%b ua=%h b=%h want all 0",
                      out_a_ready, out_unit_valid, out_b_valid, out_unit_a, out_b);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_b_valid || out_unit_valid) seen = 1'b1;
    end
    vec++;
    if (seen) begin err++; $display("FAIL abort_no_result: got activity=1 want 0"); end
    issue(c, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    vec++;
    if (sb.size() != 0) begin err++; $display("FAIL abort_recover: got pending=%0d want 0", sb.size()); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    repeat (3) @(negedge clk);
    vec++;
    if (sb.size() != 0) begin err++; $display("FAIL final_drain: got pending=%0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
